load_use_detect: RTL
====================

Name: load_use_detect

Overview:
- Hazard-detection end of the load-use interface in the 5-stage MIPS pipeline.
- Compares ID-stage source registers against a load in EX. On a match it stalls PC and IF/ID and injects a bubble into ID/EX.
- Drives per-operand load-use flags to the EX operand-hold logic.
- Tracks the load through MEM and freezes the whole pipeline while data memory is not ready.

Parameters:
REG_ADDR_W, 5, register-number width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
id_valid  input  1  ID holds a real instruction
id_rs  input  REG_ADDR_W  ID source register 1
id_rt  input  REG_ADDR_W  ID source register 2
id_use_rs  input  1  ID instruction reads rs
id_use_rt  input  1  ID instruction reads rt
ex_mem_read  input  1  EX instruction is a load
ex_reg_write  input  1  EX instruction writes a register
ex_rd  input  REG_ADDR_W  EX destination register
dmem_ready  input  1  data memory completes the MEM access this cycle
flush  input  1  interrupt/exception flush request
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
id_ex_bubble  output  1  load NOP into ID/EX
pipe_freeze  output  1  hold all pipeline registers, including EX/MEM and MEM/WB
load_use_rs  output  1  rs operand of stalled instruction depends on the load
load_use_rt  output  1  rt operand of stalled instruction depends on the load
stall_cycles  output  CNT_W  saturating count of cycles with any stall output high

Behaviour:
- Reset (rst==0 at a rising edge): state=RUN, stall_cycles=0. All other outputs are combinational and are 0 while in RUN with no hazard.
- hit_rs = id_valid & id_use_rs & (id_rs==ex_rd). hit_rt is defined the same way with rt.
- hazard = ex_mem_read & ex_reg_write & (ex_rd!=0) & (hit_rs|hit_rt). Register 0 never produces a hazard.
- States: RUN, LOADWAIT. Outputs are Mealy (same-cycle).
- RUN, flush=1: all outputs 0, next=RUN. Flush wins over hazard.
- RUN, hazard=1 and flush=0:
  - pc_stall=if_id_stall=id_ex_bubble=1.
  - load_use_rs=hit_rs, load_use_rt=hit_rt. Both may be 1.
  - next=LOADWAIT.
- RUN, otherwise: all outputs 0, next=RUN.
- LOADWAIT (load now in MEM, bubble in EX): the hazard term is ignored, so no back-to-back stall is possible.
  - dmem_ready=0: pipe_freeze=pc_stall=if_id_stall=1, id_ex_bubble=0, stay in LOADWAIT. flush is ignored while frozen.
  - dmem_ready=1: all outputs 0, next=RUN. Any flush is passed downstream by the flush logic itself.
- Latency: a single-cycle memory costs exactly 1 stall cycle. Each dmem_ready=0 cycle adds 1 more.
- load_use_rs/rt are high only in the hazard cycle. The EX operand-hold logic registers them.
- stall_cycles increments by 1 on every cycle where pc_stall=1 and saturates at all-ones.
- Reset mid-LOADWAIT: state=RUN next cycle, counter cleared, no residual freeze.

Decomposition:
- Shared package holds:
  - state encoding (RUN=1'b0, LOADWAIT=1'b1)
  - REG_ZERO constant
  - the REG_ADDR_W default
- Sub-module hazard_compare (purely combinational): produces hit_rs, hit_rt, hazard.
- FSM and counter live in the top module.

Test Plan:
- lw $8 in EX (ex_rd=8, mem_read=1, reg_write=1); ID add uses rs=8, rt=9; dmem_ready=1:
  - hazard cycle: pc_stall=if_id_stall=id_ex_bubble=1, load_use_rs=1, load_use_rt=0.
  - next cycle: all outputs 0.
  - stall_cycles=1.
- Same as above with rs=rt=8: load_use_rs=load_use_rt=1 for one cycle.
- ex_rd=0 load with ID rs=0: no stall, outputs stay 0. Also ex_mem_read=0 with rd match: no stall.
- Hazard, then dmem_ready=0 for 3 cycles, then 1:
  - pipe_freeze=1 for exactly 3 cycles, id_ex_bubble=0 during them.
  - then RUN, stall_cycles=4.
- Hazard coincident with flush=1: no stall outputs, state stays RUN. flush during a freeze: freeze held until dmem_ready.
- rst=0 asserted during LOADWAIT freeze: next cycle all outputs 0, stall_cycles=0. Also preload counter near max: saturates at 16'hFFFF.

Source files
------------

// File: rtl/load_use_detect_pkg.sv
// Shared definitions for the load-use hazard detector: FSM state encoding,
// the hard-wired zero register and the default register-number width.
package load_use_detect_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int REG_ZERO       = 0;

  localparam logic [0:0] STATE_RUN      = 1'b0;
  localparam logic [0:0] STATE_LOADWAIT = 1'b1;

endpackage

// File: rtl/load_use_detect_hazard_compare.sv
// Combinational comparison of the ID-stage source registers against the
// destination of a load sitting in EX.
module load_use_detect_hazard_compare
  import load_use_detect_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hit_rs,
  output logic                  hit_rt,
  output logic                  hazard
);

  logic ex_is_load;

  always_comb begin
    hit_rs     = id_valid & id_use_rs & (id_rs == ex_rd);
    hit_rt     = id_valid & id_use_rt & (id_rt == ex_rd);
    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    ex_is_load = ex_mem_read & ex_reg_write & (ex_rd != REG_ADDR_W'(REG_ZERO));
    hazard     = ex_is_load & (hit_rs | hit_rt);
  end

endmodule

// File: rtl/load_use_detect.sv
// Load-use hazard detector: stalls the front end for one cycle behind a load,
// then freezes the whole pipeline while data memory is not ready.
module load_use_detect
  import load_use_detect_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  dmem_ready,
  input  logic                  flush,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_bubble,
  output logic                  pipe_freeze,
  output logic                  load_use_rs,
  output logic                  load_use_rt,
  output logic [CNT_W-1:0]      stall_cycles
);

  logic             hit_rs;
  logic             hit_rt;
  logic             hazard;
  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  load_use_detect_hazard_compare #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_compare (
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .hit_rs       (hit_rs),
    .hit_rt       (hit_rt),
    .hazard       (hazard)
  );

  always_comb begin
    state_d      = state_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    load_use_rs  = 1'b0;
    load_use_rt  = 1'b0;
    case (state_q)
      STATE_RUN: begin
        // A flush discards the dependent instruction, so it outranks the stall.
        if (hazard && !flush) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          load_use_rs  = hit_rs;
          load_use_rt  = hit_rt;
          state_d      = STATE_LOADWAIT;
        end
      end
      STATE_LOADWAIT: begin
        // The bubble occupies EX, so no new hazard is evaluated here.
        if (!dmem_ready) begin
          pipe_freeze = 1'b1;
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
        end else begin
          state_d = STATE_RUN;
        end
      end
      default: state_d = STATE_RUN;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= STATE_RUN;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
